// File: rtl/alarm_timer.sv
// Countdown timer for the vehicle alarm FSM: four reprogrammable second-based delays.
// Optional `remaining` output is enabled by defining ALARM_TIMER_REMAIN_EN.
module alarm_timer #(
    parameter int CLK_HZ    = 27000000,
    parameter int T_ARM_DEF = 6,
    parameter int T_DRV_DEF = 8,
    parameter int T_PAS_DEF = 15,
    parameter int T_ALM_DEF = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_timer,
    input  logic [1:0] interval,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
`ifdef ALARM_TIMER_REMAIN_EN
    output logic [3:0] remaining,
`endif
    output logic       expired,
    output logic       busy
);

    localparam int DIV_W = $clog2(CLK_HZ);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);

    typedef enum logic {
        S_IDLE,
        S_COUNT
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             expired_q, expired_d;
    logic [3:0]       dur_q [4];
    logic [3:0]       dur_d [4];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            div_q     <= '0;
            expired_q <= 1'b0;
            dur_q[0]  <= 4'(T_ARM_DEF);
            dur_q[1]  <= 4'(T_DRV_DEF);
            dur_q[2]  <= 4'(T_PAS_DEF);
            dur_q[3]  <= 4'(T_ALM_DEF);
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            div_q     <= div_d;
            expired_q <= expired_d;
            dur_q     <= dur_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        div_d     = div_q;
        expired_d = 1'b0;
        dur_d     = dur_q;

        if (reprogram) begin
            dur_d[time_param_sel] = time_value;
        end

        // Start reads dur_q, so a same-edge reprogram of that register loads the old value.
        if (start_timer) begin
            state_d = S_COUNT;
            count_d = dur_q[interval];
            div_d   = '0;
        end else if (state_q == S_COUNT) begin
            // A zero-length load expires on the first edge after the start.
            if ((count_q == 4'd0) || (div_q == DIV_MAX && count_q == 4'd1)) begin
                state_d   = S_IDLE;
                count_d   = '0;
                div_d     = '0;
                expired_d = 1'b1;
            end else if (div_q == DIV_MAX) begin
                div_d   = '0;
                count_d = count_q - 4'd1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    assign busy    = (state_q == S_COUNT);
    assign expired = expired_q;

`ifdef ALARM_TIMER_REMAIN_EN
    assign remaining = busy ? count_q : '0;
`endif

endmodule

// File: tb/tb_alarm_timer.sv
// Self-checking bench for alarm_timer (CLK_HZ=4): directed scenarios plus random traffic
// compared each cycle against a deadline-based reference model.
module tb_alarm_timer;

    localparam int CLK_HZ = 4;

    logic       clk = 1'b0;
    logic       reset, start_timer, reprogram;
    logic [1:0] interval, time_param_sel;
    logic [3:0] time_value;
    logic       expired, busy;
`ifdef ALARM_TIMER_REMAIN_EN
    logic [3:0] remaining;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    int         cyc = 0;
    bit         m_busy = 1'b0;
    bit         m_exp = 1'b0;
    int         m_n = 0;
    int         m_start = 0;
    int         m_deadline = 0;
    logic [3:0] m_dur [4];

    alarm_timer #(
        .CLK_HZ   (CLK_HZ),
        .T_ARM_DEF(6),
        .T_DRV_DEF(8),
        .T_PAS_DEF(15),
        .T_ALM_DEF(10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_timer   (start_timer),
        .interval      (interval),
        .reprogram     (reprogram),
        .time_param_sel(time_param_sel),
        .time_value    (time_value),
`ifdef ALARM_TIMER_REMAIN_EN
        .remaining     (remaining),
`endif
        .expired       (expired),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic model_edge(input bit r, input bit st, input logic [1:0] iv,
                              input bit rp, input logic [1:0] sel, input logic [3:0] v);
        m_exp = 1'b0;
        if (r) begin
            m_busy = 1'b0;
            m_n    = 0;
            m_dur[0] = 4'd6; m_dur[1] = 4'd8; m_dur[2] = 4'd15; m_dur[3] = 4'd10;
        end else begin
            if (st) begin
                m_busy     = 1'b1;
                m_n        = int'(m_dur[iv]);
                m_start    = cyc;
                m_deadline = cyc + ((m_n == 0) ? 1 : m_n * CLK_HZ);
            end else if (m_busy && cyc == m_deadline) begin
                m_exp  = 1'b1;
                m_busy = 1'b0;
            end
            if (rp) m_dur[sel] = v;
        end
    endtask

    task automatic step(input bit r, input bit st, input logic [1:0] iv,
                        input bit rp, input logic [1:0] sel, input logic [3:0] v);
        reset = r; start_timer = st; interval = iv;
        reprogram = rp; time_param_sel = sel; time_value = v;
        @(posedge clk);
        cyc++;
        model_edge(r, st, iv, rp, sel, v);
        #1;
        check("busy", int'(busy), int'(m_busy));
        check("expired", int'(expired), int'(m_exp));
`ifdef ALARM_TIMER_REMAIN_EN
        check("remaining", int'(remaining),
              m_busy ? (m_n - (cyc - m_start) / CLK_HZ) : 0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'd0);
    endtask

    // Steps idle cycles after a start edge until expired appears; bounded.
    task automatic wait_exp(input string tag, input int exp_lat);
        int lat = -1;
        for (int k = 1; k <= exp_lat + 8 && lat < 0; k++) begin
            step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'd0);
            if (expired) lat = k;
        end
        check(tag, lat, exp_lat);
    endtask

    initial begin
        step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'd0);
        step(1'b1, 1'b1, 2'd1, 1'b1, 2'd1, 4'd1);  // reset beats start/reprogram
        check("reset_busy", int'(busy), 0);
        check("reset_expired", int'(expired), 0);

        // default arm delay 6 s
        step(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 4'd0);
        wait_exp("arm_default_lat", 24);
        idle(3);

        // reprogrammed driver delay 3 s
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 4'd3);
        step(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 4'd0);
        wait_exp("driver_reprog_lat", 12);
        idle(2);

        // restart passenger run with alarm run at +20
        step(1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 4'd0);
        idle(19);
        step(1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 4'd0);
        wait_exp("restart_lat", 40);
        idle(2);

        // zero-length alarm hold
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 4'd0);
        step(1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 4'd0);
        check("zero_busy_one_cycle", int'(busy), 1);
        wait_exp("zero_len_lat", 1);
        check("zero_busy_fall", int'(busy), 0);
        idle(2);

        // reset mid-countdown restores defaults
        step(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 4'd0);
        idle(9);
        step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'd0);
        check("abort_busy", int'(busy), 0);
        idle(60);
        step(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 4'd0);
        wait_exp("driver_after_reset_lat", 32);
        idle(2);

        // same-edge start and reprogram of the same register
        step(1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 4'd2);
        wait_exp("same_edge_old_lat", 24);
        step(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 4'd0);
        wait_exp("same_edge_new_lat", 8);

        // restart exactly at an expiry edge suppresses the pulse
        step(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 4'd0);
        idle(7);
        step(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 4'd0);
        check("restart_at_expiry", int'(expired), 0);
        wait_exp("restart_at_expiry_lat", 8);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 399) == 0,
                 $urandom_range(0, 49) == 0,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 19) == 0,
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
